// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M DIV/DIVU/REM/REMU unit.
// Restoring division, one quotient bit per clock, fixed latency of BUS_WIDTH+2.
`default_nettype none

module div_unit #(
  parameter int BUS_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [BUS_WIDTH-1:0] src_a,
  input  logic [BUS_WIDTH-1:0] src_b,
  input  logic [1:0]           div_op,
  output logic                 busy,
  output logic                 done,
  output logic [BUS_WIDTH-1:0] div_result
);

  localparam int CW = $clog2(BUS_WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_CALC = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [BUS_WIDTH-1:0] a_q, a_d;
  logic [BUS_WIDTH-1:0] b_q, b_d;
  logic [BUS_WIDTH-1:0] quo_q, quo_d;
  logic [BUS_WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 negq_q, negq_d;
  logic                 negr_q, negr_d;
  logic                 dz_q, dz_d;
  logic [BUS_WIDTH-1:0] res_q, res_d;
  logic                 done_q, done_d;
  logic                 busy_q, busy_d;

  logic                 is_signed;
  logic                 a_neg, b_neg;
  logic [BUS_WIDTH:0]   shifted;
  logic                 fits;
  logic [BUS_WIDTH-1:0] diff;

  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & a_q[BUS_WIDTH-1];
  assign b_neg     = is_signed & b_q[BUS_WIDTH-1];
  assign shifted   = {rem_q, quo_q[BUS_WIDTH-1]};
  assign fits      = (shifted >= {1'b0, b_q});
  // Only used when fits, so the true difference is below 2^BUS_WIDTH.
  assign diff      = shifted[BUS_WIDTH-1:0] - b_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      dz_q    <= 1'b0;
      res_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      dz_q    <= dz_d;
      res_q   <= res_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    dz_d    = dz_q;
    res_d   = res_q;
    done_d  = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      S_IDLE: begin
        // The done cycle is still the tail of the previous operation.
        if (start && !done_q) begin
          op_d    = div_op;
          a_d     = src_a;
          b_d     = src_b;
          busy_d  = 1'b1;
          state_d = S_PREP;
        end
      end
      S_PREP: begin
        quo_d   = a_neg ? -a_q : a_q;
        b_d     = b_neg ? -b_q : b_q;
        negq_d  = a_q[BUS_WIDTH-1] ^ b_q[BUS_WIDTH-1];
        negr_d  = a_q[BUS_WIDTH-1];
        dz_d    = (b_q == '0);
        rem_d   = '0;
        cnt_d   = CW'(BUS_WIDTH);
        state_d = S_CALC;
      end
      S_CALC: begin
        rem_d = fits ? diff : shifted[BUS_WIDTH-1:0];
        quo_d = {quo_q[BUS_WIDTH-2:0], fits};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        unique case (op_q)
          2'b00:   res_d = dz_q ? '1 : (negq_q ? -quo_q : quo_q);
          2'b01:   res_d = dz_q ? '1 : quo_q;
          2'b10:   res_d = dz_q ? a_q : (negr_q ? -rem_q : rem_q);
          default: res_d = dz_q ? a_q : rem_q;
        endcase
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign div_result = res_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit with a plain-arithmetic reference model.
`default_nettype none

module tb_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [1:0]   div_op = 2'b00;
  logic         busy;
  logic         done;
  logic [W-1:0] div_result;

  div_unit #(.BUS_WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .src_a      (src_a),
    .src_b      (src_b),
    .div_op     (div_op),
    .busy       (busy),
    .done       (done),
    .div_result (div_result)
  );

  typedef struct {
    logic [W-1:0] res;
    int           cyc;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic [W-1:0] last_res = '0;
  bit           prev_done = 1'b0;
  int           accept_cyc = 0;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference: RISC-V M semantics from ordinary 64-bit arithmetic.
  function automatic logic [W-1:0] ref_model(input logic [1:0] op, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint sa, sbv, q, r;
    logic [W-1:0] ua;
    if (b == '0) return op[1] ? a : '1;
    if (!op[0]) begin
      sa  = $signed(a);
      sbv = $signed(b);
      q   = sa / sbv;
      r   = sa % sbv;
      return op[1] ? r[W-1:0] : q[W-1:0];
    end
    ua = a;
    return op[1] ? (ua % b) : (ua / b);
  endfunction

  task automatic check_vec(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is seen.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (!rst_n) begin
      sb.delete();
      last_res  = '0;
      prev_done = 1'b0;
    end else begin
      if (done) begin
        check_int("done_single_pulse", int'(prev_done), 0);
        check_int("busy_low_at_done", int'(busy), 0);
        if (sb.size() == 0) begin
          check_int("unexpected_done", 1, 0);
        end else begin
          e = sb.pop_front();
          check_vec($sformatf("result op=%0d a=%h b=%h", e.op, e.a, e.b), div_result, e.res);
          check_int($sformatf("latency op=%0d", e.op), cyc, e.cyc);
          last_res = e.res;
        end
      end else begin
        check_vec("result_hold", div_result, last_res);
      end
      prev_done = done;
    end
  end

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    div_op = op;
    src_a  = a;
    src_b  = b;
    e.res = ref_model(op, a, b);
    e.cyc = cyc + 1 + LAT;
    e.op  = op;
    e.a   = a;
    e.b   = b;
    sb.push_back(e);
    accept_cyc = cyc + 1;
    @(negedge clk);
    start  = 1'b0;
    src_a  = W'($urandom);
    src_b  = W'($urandom);
    div_op = 2'($urandom);
    check_int("busy_after_accept", int'(busy), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < LAT + 10) begin
      @(negedge clk);
      n++;
    end
    if (!done) check_int("done_timeout", 0, 1);
  endtask

  task automatic run(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    issue(op, a, b);
    wait_done();
  endtask

  function automatic logic [W-1:0] rand_operand();
    int sel = $urandom_range(0, 9);
    case (sel)
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3, 4:    return W'($urandom_range(1, 15));
      5:       return -W'($urandom_range(1, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #12;
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_done", int'(done), 0);
    check_vec("reset_result", div_result, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run(2'b01, 32'd100, 32'd7);
    run(2'b11, 32'd100, 32'd7);
    run(2'b00, -32'sd7, 32'd2);
    run(2'b10, -32'sd7, 32'd2);
    run(2'b10, 32'd7, -32'sd2);
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b01, 32'hFFFF_FFFF, 32'd1);
    run(2'b00, 32'd5, 32'd0);
    run(2'b10, 32'd5, 32'd0);
    run(2'b11, 32'hDEAD_BEEF, 32'd0);
    run(2'b01, 32'hDEAD_BEEF, 32'd0);

    // Start pulse mid-operation must be ignored.
    issue(2'b01, 32'd1000, 32'd9);
    repeat (5) @(negedge clk);
    start = 1'b1; src_a = 32'd77; src_b = 32'd5; div_op = 2'b11;
    @(negedge clk);
    start = 1'b0;
    wait_done();

    // Start during the done cycle is ignored.
    issue(2'b00, -32'sd100, 32'd3);
    wait_done();
    start = 1'b1; src_a = 32'd50; src_b = 32'd4; div_op = 2'b01;
    @(negedge clk);
    start = 1'b0;
    check_int("start_in_done_ignored", int'(busy), 0);
    repeat (LAT + 5) @(negedge clk);

    // Back-to-back operations, then randomized traffic.
    run(2'b01, 32'd12345, 32'd11);
    run(2'b11, 32'd12345, 32'd11);
    for (int i = 0; i < 30; i++) begin
      run(2'($urandom), rand_operand(), rand_operand());
    end

    // Asynchronous reset in the middle of CALC.
    run(2'b01, 32'd100, 32'd7);
    issue(2'b01, 32'hFFFF_0000, 32'd3);
    while (cyc < accept_cyc + 11) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_int("midreset_busy", int'(busy), 0);
    check_int("midreset_done", int'(done), 0);
    check_vec("midreset_result", div_result, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 5) @(negedge clk);
    run(2'b01, 32'd9, 32'd3);

    repeat (3) @(negedge clk);
    check_int("scoreboard_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
